// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures hsync/vsync period and pulse widths on
// pixel-enable cycles and tracks lock against the expected video mode.
module vga_sync_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int LOCK_FRAMES = 2,
   parameter int CW          = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          hsync,
   input  logic          vsync,
   output logic [CW-1:0] h_total,
   output logic [CW-1:0] h_sync_w,
   output logic [CW-1:0] v_total,
   output logic [CW-1:0] v_sync_w,
   output logic          locked,
   output logic          lock_err,
   output logic [15:0]   frame_cnt
);

   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
   localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
   localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
   localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
   localparam logic [7:0]    LOCK_C    = 8'(LOCK_FRAMES);

   localparam logic [1:0] ST_UNLOCK  = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   logic          hs_q, hs_d, vs_q, vs_d;
   logic [CW-1:0] pix_q, pix_d, hsw_q, hsw_d, line_q, line_d, vsw_q, vsw_d;
   logic [CW-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
   logic [CW-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [7:0]    match_cnt_q, match_cnt_d;
   logic          lock_err_q, lock_err_d;

   logic          hs_fall, hs_rise, vs_fall, vs_rise;
   logic [CW-1:0] pix_len, line_inc, vsw_inc, h_meas;
   logic          frame_match, line_bad;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   assign hs_fall = en && hs_q && !hsync;
   assign hs_rise = en && !hs_q && hsync;
   assign vs_fall = en && vs_q && !vsync;
   assign vs_rise = en && !vs_q && vsync;

   // Length of the line ending now (includes the edge cycle itself).
   assign pix_len  = sat_inc(pix_q);
   assign line_inc = hs_fall ? sat_inc(line_q) : line_q;
   assign vsw_inc  = (hs_fall && !vsync) ? sat_inc(vsw_q) : vsw_q;
   assign h_meas   = hs_fall ? pix_len : h_total_q;

   // Pulse widths use the values held before this cycle; the line count includes this cycle's line.
   assign frame_match = (h_meas == H_TOTAL_C) && (h_sync_w_q == H_SYNC_C) &&
                        (line_inc == V_TOTAL_C) && (v_sync_w_q == V_SYNC_C);
   assign line_bad    = hs_fall && (pix_len != H_TOTAL_C);

   always_comb begin
      hs_d        = hs_q;
      vs_d        = vs_q;
      pix_d       = pix_q;
      hsw_d       = hsw_q;
      line_d      = line_q;
      vsw_d       = vsw_q;
      h_total_d   = h_total_q;
      h_sync_w_d  = h_sync_w_q;
      v_total_d   = v_total_q;
      v_sync_w_d  = v_sync_w_q;
      frame_cnt_d = frame_cnt_q;

      if (en) begin
         hs_d  = hsync;
         vs_d  = vsync;
         pix_d = hs_fall ? '0 : pix_len;
      end
      if (hs_fall) begin
         h_total_d = pix_len;
      end

      if (hs_fall) begin
         hsw_d = '0;
      end else if (hs_rise) begin
         h_sync_w_d = sat_inc(hsw_q);
         hsw_d      = '0;
      end else if (en && !hsync) begin
         hsw_d = sat_inc(hsw_q);
      end

      if (vs_fall) begin
         v_total_d   = line_inc;
         line_d      = '0;
         frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
         line_d = line_inc;
      end

      if (vs_rise) begin
         v_sync_w_d = vsw_inc;
         vsw_d      = '0;
      end else begin
         vsw_d = vsw_inc;
      end
   end

   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      lock_err_d  = 1'b0;
      case (state_q)
         ST_UNLOCK: begin
            // The first frame end after reset only opens a measurement window.
            if (vs_fall) begin
               state_d     = ST_MEASURE;
               match_cnt_d = '0;
            end
         end
         ST_MEASURE: begin
            if (vs_fall) begin
               if (!frame_match) begin
                  match_cnt_d = '0;
               end else if (match_cnt_q + 8'd1 == LOCK_C) begin
                  state_d     = ST_LOCKED;
                  match_cnt_d = '0;
               end else begin
                  match_cnt_d = match_cnt_q + 8'd1;
               end
            end
         end
         ST_LOCKED: begin
            if (line_bad || (vs_fall && !frame_match)) begin
               state_d     = ST_MEASURE;
               match_cnt_d = '0;
               lock_err_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_UNLOCK;
            match_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         pix_q       <= '0;
         hsw_q       <= '0;
         line_q      <= '0;
         vsw_q       <= '0;
         h_total_q   <= '0;
         h_sync_w_q  <= '0;
         v_total_q   <= '0;
         v_sync_w_q  <= '0;
         frame_cnt_q <= '0;
         state_q     <= ST_UNLOCK;
         match_cnt_q <= '0;
         lock_err_q  <= 1'b0;
      end else begin
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         pix_q       <= pix_d;
         hsw_q       <= hsw_d;
         line_q      <= line_d;
         vsw_q       <= vsw_d;
         h_total_q   <= h_total_d;
         h_sync_w_q  <= h_sync_w_d;
         v_total_q   <= v_total_d;
         v_sync_w_q  <= v_sync_w_d;
         frame_cnt_q <= frame_cnt_d;
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         lock_err_q  <= lock_err_d;
      end
   end

   assign h_total   = h_total_q;
   assign h_sync_w  = h_sync_w_q;
   assign v_total   = v_total_q;
   assign v_sync_w  = v_sync_w_q;
   assign frame_cnt = frame_cnt_q;
   assign locked    = (state_q == ST_LOCKED);
   assign lock_err  = lock_err_q;

endmodule
